tile_clock_gate_sequencer: RTL and testbench

Controller that sequences the tile clock-gate enable and tile reset so a tile is never gated mid-transaction. Arbitrates gate/ungate requests from NUM_REQ requesters (e.g. power manager, debug module) round-robin. Runs quiesce → reset → gate on the way down and ungate → reset-hold → release on the way up. Sits between the requesters and the per-tile clock-gater register/enable path in the uncore clock domain.

---
 rtl/tile_clock_gate_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_tile_clock_gate_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_clock_gate_sequencer.sv
// Tile clock-gate sequencer: round-robin gate/ungate arbitration, quiesce -> reset -> gate going down,
// ungate -> reset-hold -> release going up. Define TILE_CG_GATED_CYCLES_EN to add the gated_cycles counter.
module tile_clock_gate_sequencer #(
  parameter int NUM_REQ         = 2,
  parameter int ID_W            = 1,
  parameter int CNT_W           = 8,
  parameter int QUIESCE_TIMEOUT = 200,
  parameter int RESET_HOLD      = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [NUM_REQ-1:0] req_gate,
  output logic [NUM_REQ-1:0] req_ready,
  output logic               resp_valid,
  output logic [ID_W-1:0]    resp_id,
  output logic               resp_ok,
  output logic               quiesce_req,
  input  logic               quiesce_ack,
  output logic               clock_en,
  output logic               tile_reset,
  output logic               gated,
  output logic               timeout_err,
  input  logic               err_clear
`ifdef TILE_CG_GATED_CYCLES_EN
  ,
  output logic [31:0]        gated_cycles
`endif
);

  typedef enum logic [2:0] {RUN, QUIESCE, RST_DN, GATED, RST_UP} state_t;

  localparam logic             QT_EN  = (QUIESCE_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] QT_LIM = CNT_W'(QUIESCE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] RH_LIM = CNT_W'(RESET_HOLD - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_ok_q, resp_ok_d;
  logic [ID_W-1:0]   resp_id_q, resp_id_d;
  logic              err_q, err_d;

  logic              arb_en;
  logic              found;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]   win_id;
  logic [ID_W-1:0]   win_nxt;
  logic [ID_W:0]     sum;
  logic [ID_W-1:0]   idx;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Arbitration is held off while reset is asserted so req_ready reads zero in reset.
  assign arb_en = reset && ((state_q == RUN) || (state_q == GATED));

  always_comb begin
    grant  = '0;
    win_id = '0;
    found  = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(NUM_REQ)) sum = sum - (ID_W+1)'(NUM_REQ);
      idx = sum[ID_W-1:0];
      if (arb_en && !found && req_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        win_id     = idx;
      end
    end
  end

  assign win_nxt = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ptr_d        = ptr_q;
    id_d         = id_q;
    resp_valid_d = 1'b0;
    resp_ok_d    = resp_ok_q;
    resp_id_d    = resp_id_q;
    err_d        = err_q & ~err_clear;
    if (found) begin
      ptr_d = win_nxt;
      id_d  = win_id;
    end
    case (state_q)
      RUN: begin
        if (found) begin
          if (req_gate[win_id]) begin
            state_d = QUIESCE;
            cnt_d   = '0;
          end else begin
            resp_valid_d = 1'b1;
            resp_ok_d    = 1'b1;
            resp_id_d    = win_id;
          end
        end
      end
      QUIESCE: begin
        // Ack takes priority over a timeout landing in the same cycle.
        if (quiesce_ack) begin
          state_d = RST_DN;
          cnt_d   = '0;
        end else if (QT_EN && (cnt_q == QT_LIM)) begin
          state_d      = RUN;
          resp_valid_d = 1'b1;
          resp_ok_d    = 1'b0;
          resp_id_d    = id_q;
          err_d        = 1'b1;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      RST_DN: begin
        if (cnt_q == RH_LIM) begin
          state_d      = GATED;
          resp_valid_d = 1'b1;
          resp_ok_d    = 1'b1;
          resp_id_d    = id_q;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      GATED: begin
        if (found) begin
          if (!req_gate[win_id]) begin
            state_d = RST_UP;
            cnt_d   = '0;
          end else begin
            resp_valid_d = 1'b1;
            resp_ok_d    = 1'b1;
            resp_id_d    = win_id;
          end
        end
      end
      RST_UP: begin
        if (cnt_q == RH_LIM) begin
          state_d      = RUN;
          resp_valid_d = 1'b1;
          resp_ok_d    = 1'b1;
          resp_id_d    = id_q;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= RUN;
      cnt_q        <= '0;
      ptr_q        <= '0;
      id_q         <= '0;
      resp_valid_q <= 1'b0;
      resp_ok_q    <= 1'b0;
      resp_id_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ptr_q        <= ptr_d;
      id_q         <= id_d;
      resp_valid_q <= resp_valid_d;
      resp_ok_q    <= resp_ok_d;
      resp_id_q    <= resp_id_d;
      err_q        <= err_d;
    end
  end

  assign req_ready   = grant;
  assign resp_valid  = resp_valid_q;
  assign resp_ok     = resp_ok_q;
  assign resp_id     = resp_id_q;
  assign timeout_err = err_q;
  assign quiesce_req = (state_q == QUIESCE);
  assign clock_en    = (state_q != GATED);
  assign gated       = (state_q == GATED);
  assign tile_reset  = (state_q == RST_DN) || (state_q == GATED) || (state_q == RST_UP);

`ifdef TILE_CG_GATED_CYCLES_EN
  logic [31:0] gcyc_q, gcyc_d;

  always_comb begin
    gcyc_d = gcyc_q;
    if (err_clear) gcyc_d = '0;
    else if ((state_q == GATED) && (gcyc_q != 32'hFFFF_FFFF)) gcyc_d = gcyc_q + 32'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) gcyc_q <= '0;
    else        gcyc_q <= gcyc_d;
  end

  assign gated_cycles = gcyc_q;
`else
  // No gated-cycle counter in this build.
`endif

endmodule

// File: tb/tb_tile_clock_gate_sequencer.sv
// Bench for tile_clock_gate_sequencer: directed and random transactions against a transaction-level model.
module tb_tile_clock_gate_sequencer;
  localparam int NUM_REQ = 2;
  localparam int ID_W    = 1;
  localparam int CNT_W   = 8;
  localparam int QT      = 200;
  localparam int RH      = 8;

  // Expected output pattern: {clock_en, tile_reset, quiesce_req, gated, resp_valid}
  localparam logic [4:0] P_RUN   = 5'b10000;
  localparam logic [4:0] P_QUI   = 5'b10100;
  localparam logic [4:0] P_RST   = 5'b11000;
  localparam logic [4:0] P_GATED = 5'b01010;
  localparam logic [4:0] P_RUN_R = 5'b10001;
  localparam logic [4:0] P_GAT_R = 5'b01011;

  logic               clock;
  logic               reset;
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_gate;
  logic [NUM_REQ-1:0] req_ready;
  logic               resp_valid;
  logic [ID_W-1:0]    resp_id;
  logic               resp_ok;
  logic               quiesce_req;
  logic               quiesce_ack;
  logic               clock_en;
  logic               tile_reset;
  logic               gated;
  logic               timeout_err;
  logic               err_clear;
`ifdef TILE_CG_GATED_CYCLES_EN
  logic [31:0]        gated_cycles;
`endif

  int n_chk;
  int n_fail;
  int rr;
  bit tile_on;
  bit err_m;

  tile_clock_gate_sequencer #(
    .NUM_REQ(NUM_REQ), .ID_W(ID_W), .CNT_W(CNT_W),
    .QUIESCE_TIMEOUT(QT), .RESET_HOLD(RH)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_gate(req_gate), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_ok(resp_ok),
    .quiesce_req(quiesce_req), .quiesce_ack(quiesce_ack),
    .clock_en(clock_en), .tile_reset(tile_reset), .gated(gated),
    .timeout_err(timeout_err), .err_clear(err_clear)
`ifdef TILE_CG_GATED_CYCLES_EN
    , .gated_cycles(gated_cycles)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Round-robin winner from the model pointer; -1 when nobody requests.
  function automatic int pick(input logic [NUM_REQ-1:0] vm);
    logic [31:0] vw;
    int j;
    vw = 32'(vm);
    pick = -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (rr + k) % NUM_REQ;
      if (pick < 0 && ((vw >> j) & 32'd1) != 32'd0) pick = j;
    end
  endfunction

  task automatic expect_cycle(input string tag, input logic ack_v, input logic noise, input logic set_err,
                              input logic [4:0] e, input logic e_ok, input int e_id);
    @(posedge clock);
    err_m = set_err ? 1'b1 : (err_clear ? 1'b0 : err_m);
    #1;
    quiesce_ack = ack_v;
    req_valid   = noise ? NUM_REQ'($urandom) : '0;
    req_gate    = NUM_REQ'($urandom);
    #1;
    chk({tag, ".clock_en"},    32'(clock_en),    32'(e[4]));
    chk({tag, ".tile_reset"},  32'(tile_reset),  32'(e[3]));
    chk({tag, ".quiesce_req"}, 32'(quiesce_req), 32'(e[2]));
    chk({tag, ".gated"},       32'(gated),       32'(e[1]));
    chk({tag, ".resp_valid"},  32'(resp_valid),  32'(e[0]));
    chk({tag, ".timeout_err"}, 32'(timeout_err), 32'(err_m));
    chk({tag, ".req_ready"},   32'(req_ready),   32'd0);
    if (e[0]) begin
      chk({tag, ".resp_ok"}, 32'(resp_ok), 32'(e_ok));
      chk({tag, ".resp_id"}, 32'(resp_id), 32'(e_id));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      expect_cycle("idle", 1'b0, 1'b0, 1'b0, tile_on ? P_RUN : P_GATED, 1'b0, 0);
  endtask

  // One request presented in the current cycle; returns in the cycle its response is seen.
  task automatic run_txn(input logic [NUM_REQ-1:0] vm, input logic [NUM_REQ-1:0] gm, input int ack_at);
    int  w;
    bit  g;
    bit  done;
    w = pick(vm);
    req_valid = vm;
    req_gate  = gm;
    #1;
    chk("grant", 32'(req_ready), (w < 0) ? 32'd0 : (32'd1 << w));
    if (w < 0) return;
    g  = (((32'(gm) >> w) & 32'd1) != 32'd0);
    rr = (w + 1) % NUM_REQ;
    if (tile_on && g) begin
      done = 1'b0;
      for (int q = 1; q <= 5000 && !done; q++) begin
        expect_cycle("quiesce", (q == ack_at), 1'b1, 1'b0, P_QUI, 1'b0, 0);
        if (q == ack_at) done = 1'b1;
        else if (QT != 0 && q == QT) begin
          expect_cycle("timeout", 1'b0, 1'b0, 1'b1, P_RUN_R, 1'b0, w);
          return;
        end
      end
      if (!done) begin
        n_chk++;
        n_fail++;
        $display("FAIL quiesce_bound: no completion within 5000 cycles");
        return;
      end
      for (int c = 0; c < RH; c++) expect_cycle("rst_dn", 1'b0, 1'b1, 1'b0, P_RST, 1'b0, 0);
      expect_cycle("gate_done", 1'b0, 1'b0, 1'b0, P_GAT_R, 1'b1, w);
      tile_on = 1'b0;
    end else if (tile_on) begin
      expect_cycle("noop_run", 1'b0, 1'b0, 1'b0, P_RUN_R, 1'b1, w);
    end else if (!g) begin
      for (int c = 0; c < RH; c++) expect_cycle("rst_up", 1'b0, 1'b1, 1'b0, P_RST, 1'b0, 0);
      expect_cycle("ungate_done", 1'b0, 1'b0, 1'b0, P_RUN_R, 1'b1, w);
      tile_on = 1'b1;
    end else begin
      expect_cycle("noop_gated", 1'b0, 1'b0, 1'b0, P_GAT_R, 1'b1, w);
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0; rr = 0; tile_on = 1'b1; err_m = 1'b0;
    reset = 1'b0; req_valid = '1; req_gate = '1; quiesce_ack = 1'b0; err_clear = 1'b0;

    repeat (3) @(posedge clock);
    #2;
    chk("rst.clock_en",    32'(clock_en),    32'd1);
    chk("rst.tile_reset",  32'(tile_reset),  32'd0);
    chk("rst.quiesce_req", 32'(quiesce_req), 32'd0);
    chk("rst.gated",       32'(gated),       32'd0);
    chk("rst.timeout_err", 32'(timeout_err), 32'd0);
    chk("rst.resp_valid",  32'(resp_valid),  32'd0);
    chk("rst.req_ready",   32'(req_ready),   32'd0);
    req_valid = '0;
    reset = 1'b1;
    idle(2);

    // Both requesters with no-op ungates in RUN: grants alternate.
    repeat (4) run_txn('1, '0, 0);
    idle(1);

    // Gate with ack in the 5th quiesce cycle, then ungate.
    run_txn(NUM_REQ'(1), NUM_REQ'(1), 5);
    idle(3);
    run_txn(NUM_REQ'(1), '0, 0);
    idle(2);

    // Quiesce timeout, then clear the sticky flag.
    run_txn(NUM_REQ'(1), NUM_REQ'(1), 0);
    idle(1);
    err_clear = 1'b1;
    idle(1);
    err_clear = 1'b0;
    idle(1);

    // Timeout with err_clear held: the new set wins.
    err_clear = 1'b1;
    run_txn(NUM_REQ'(1), NUM_REQ'(1), 0);
    err_clear = 1'b0;
    idle(1);
    err_clear = 1'b1;
    idle(1);
    err_clear = 1'b0;

    // Ack exactly at the timeout limit, then a gate no-op and an ungate while gated.
    run_txn(NUM_REQ'(2), NUM_REQ'(2), QT);
    idle(2);
    run_txn('1, '1, 0);
    run_txn('1, '0, 0);
    idle(1);

    // Reset asserted in the middle of the reset-down hold.
    req_valid = NUM_REQ'(1);
    req_gate  = NUM_REQ'(1);
    #1;
    chk("midrst.grant", 32'(req_ready), 32'd1 << pick(NUM_REQ'(1)));
    expect_cycle("midrst.quiesce", 1'b1, 1'b0, 1'b0, P_QUI, 1'b0, 0);
    for (int c = 0; c < 3; c++) expect_cycle("midrst.rst_dn", 1'b0, 1'b0, 1'b0, P_RST, 1'b0, 0);
    reset = 1'b0;
    #1;
    chk("midrst.clock_en",   32'(clock_en),   32'd1);
    chk("midrst.tile_reset", 32'(tile_reset), 32'd0);
    chk("midrst.gated",      32'(gated),      32'd0);
    chk("midrst.resp_valid", 32'(resp_valid), 32'd0);
    #1;
    reset = 1'b1;
    tile_on = 1'b1; rr = 0; err_m = 1'b0;
    idle(RH + 4);

`ifdef TILE_CG_GATED_CYCLES_EN
    run_txn(NUM_REQ'(1), NUM_REQ'(1), 3);
    chk("gcyc.entry", gated_cycles, 32'd0);
    idle(50);
    chk("gcyc.50", gated_cycles, 32'd50);
    err_clear = 1'b1;
    idle(1);
    err_clear = 1'b0;
    chk("gcyc.clear", gated_cycles, 32'd0);
    run_txn(NUM_REQ'(1), '0, 0);
    idle(1);
`endif

    // Random transactions.
    for (int t = 0; t < 30; t++) begin
      logic [NUM_REQ-1:0] vm;
      logic [NUM_REQ-1:0] gm;
      int r;
      int aa;
      vm = NUM_REQ'($urandom);
      if (vm == '0) vm = NUM_REQ'(1);
      gm = NUM_REQ'($urandom);
      r  = int'($urandom_range(0, 9));
      if (r == 0) aa = 0;
      else if (r == 1) aa = QT;
      else aa = int'($urandom_range(1, 12));
      err_clear = ($urandom_range(0, 3) == 0);
      run_txn(vm, gm, aa);
      err_clear = 1'b0;
      idle(int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
